// File: rtl/instr_enc_loader_pkg.sv
// Shared definitions for the instruction encoder/loader: format codes, fixed words, FSM states
// and the field-to-word packing and immediate range helpers.
package instr_enc_loader_pkg;

    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_HALT = 3'd6;
    localparam logic [2:0] FMT_RSVD = 3'd7;

    localparam logic [31:0] HALT_WORD = 32'h0010_0073;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

    typedef enum logic [2:0] {StIdle, StLoad, StDrain, StDone, StOvf} state_e;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } cmd_t;

    function automatic logic [31:0] encode(input cmd_t c);
        logic [31:0] w;
        case (c.fmt)
            FMT_R: w = {c.funct7, c.rs2, c.rs1, c.funct3, c.rd, c.opcode};
            FMT_I: w = {c.imm[11:0], c.rs1, c.funct3, c.rd, c.opcode};
            FMT_S: w = {c.imm[11:5], c.rs2, c.rs1, c.funct3, c.imm[4:0], c.opcode};
            FMT_B: w = {c.imm[12], c.imm[10:5], c.rs2, c.rs1, c.funct3, c.imm[4:1], c.imm[11],
                        c.opcode};
            FMT_U: w = {c.imm[31:12], c.rd, c.opcode};
            FMT_J: w = {c.imm[20], c.imm[10:1], c.imm[11], c.imm[19:12], c.rd, c.opcode};
            FMT_HALT: w = HALT_WORD;
            default: w = NOP_WORD;
        endcase
        return w;
    endfunction

    // True when the immediate fits the format without losing bits.
    function automatic logic imm_ok(input cmd_t c);
        logic ok;
        case (c.fmt)
            FMT_I, FMT_S: ok = (c.imm[31:11] == {21{c.imm[11]}});
            FMT_B:        ok = (c.imm[31:12] == {20{c.imm[12]}}) && !c.imm[0];
            FMT_J:        ok = (c.imm[31:20] == {12{c.imm[20]}}) && !c.imm[0];
            FMT_U:        ok = (c.imm[11:0] == 12'h000);
            default:      ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instr_enc_loader_if.sv
// Command channel and instruction-memory write port of the loader.
interface instr_enc_loader_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_fmt;
    logic [6:0]        cmd_opcode;
    logic [2:0]        cmd_funct3;
    logic [6:0]        cmd_funct7;
    logic [4:0]        cmd_rd;
    logic [4:0]        cmd_rs1;
    logic [4:0]        cmd_rs2;
    logic [31:0]       cmd_imm;
    logic              imem_wr_en;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output cmd_valid, cmd_fmt, cmd_opcode, cmd_funct3, cmd_funct7, cmd_rd, cmd_rs1, cmd_rs2,
               cmd_imm, imem_ready,
        input  cmd_ready, imem_wr_en, imem_addr, imem_wdata
    );

    modport slave (
        input  cmd_valid, cmd_fmt, cmd_opcode, cmd_funct3, cmd_funct7, cmd_rd, cmd_rs1, cmd_rs2,
               cmd_imm, imem_ready,
        output cmd_ready, imem_wr_en, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_enc_loader_fifo.sv
// enc_word_fifo: small synchronous FIFO of encoded words with synchronous flush.
module enc_word_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // Extra MSB on each pointer distinguishes full from empty.
    logic [PTR_W:0]   r_wptr;
    logic [PTR_W:0]   r_rptr;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign o_rdata = r_mem[r_rptr[PTR_W-1:0]];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push && !o_full) r_wptr <= r_wptr + 1'b1;
            if (i_pop && !o_empty) r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push && !o_full) r_mem[r_wptr[PTR_W-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/instr_enc_loader.sv
// Packs field-level commands into RV32I words and streams them into instruction memory.
// Optional immediate range checking is enabled by defining ENC_CHECK_EN.
module instr_enc_loader
    import instr_enc_loader_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned IMEM_WORDS = 256,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_clear,
    instr_enc_loader_if.slave    bus_if,
    output logic                 o_done,
    output logic                 o_overflow,
    output logic                 o_err
);
    localparam int unsigned CNT_W = $clog2(IMEM_WORDS + 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [CNT_W-1:0]  r_issued;
    logic [ADDR_W-3:0] r_index;
    logic              r_ovf;

    cmd_t              w_cmd;
    logic [31:0]       w_word;
    logic [31:0]       w_fifo_rdata;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_accept;
    logic              w_over;
    logic              w_bad;
    logic              w_push;
    logic              w_pop;

    assign w_cmd = '{fmt: bus_if.cmd_fmt, opcode: bus_if.cmd_opcode, funct3: bus_if.cmd_funct3,
                     funct7: bus_if.cmd_funct7, rd: bus_if.cmd_rd, rs1: bus_if.cmd_rs1,
                     rs2: bus_if.cmd_rs2, imm: bus_if.cmd_imm};
    assign w_word = encode(w_cmd);

    assign bus_if.cmd_ready = (r_state == StLoad) && !w_fifo_full;
    assign w_accept = bus_if.cmd_valid && bus_if.cmd_ready;
    assign w_over   = (r_issued == CNT_W'(IMEM_WORDS));
    assign w_push   = w_accept && !w_over && !w_bad && !i_clear;
    assign w_pop    = !w_fifo_empty && bus_if.imem_ready;

    // Address/data forced to zero when idle so every output is 0 under reset.
    assign bus_if.imem_wr_en = !w_fifo_empty;
    assign bus_if.imem_addr  = bus_if.imem_wr_en ? ADDR_W'(BASE_ADDR) + {r_index, 2'b00} : '0;
    assign bus_if.imem_wdata = bus_if.imem_wr_en ? w_fifo_rdata : '0;

    assign o_done     = (r_state == StDone);
    assign o_overflow = r_ovf;

`ifdef ENC_CHECK_EN
    logic r_err;
    assign w_bad = !imm_ok(w_cmd);
    assign o_err = r_err;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)                           r_err <= 1'b0;
        else if (i_clear)                     r_err <= 1'b0;
        else if (w_accept && !w_over && w_bad) r_err <= 1'b1;
    end
`else
    assign w_bad = 1'b0;
    assign o_err = 1'b0;
`endif

    enc_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_clear),
        .i_push  (w_push),
        .i_wdata (w_word),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (i_start) w_state_nxt = StLoad;
            StLoad: begin
                if (w_accept && w_over) begin
                    w_state_nxt = StOvf;
                end else if (w_accept && !w_bad && (w_cmd.fmt == FMT_HALT)) begin
                    w_state_nxt = StDrain;
                end
            end
            StDrain: if (w_fifo_empty) w_state_nxt = StDone;
            default: w_state_nxt = r_state;
        endcase
        if (i_clear) w_state_nxt = StIdle;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state  <= StIdle;
            r_issued <= '0;
            r_index  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (i_clear) begin
                r_issued <= '0;
                r_index  <= '0;
                r_ovf    <= 1'b0;
            end else begin
                if (w_push) r_issued <= r_issued + 1'b1;
                if (w_pop) r_index <= r_index + 1'b1;
                if (w_accept && w_over) r_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_enc_loader.sv
// Directed bench for instr_enc_loader with a queue-based reference model checked every cycle.
module tb_instr_enc_loader;

    localparam int unsigned WORDS = 8;
    localparam int unsigned DEPTH = 2;
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_DRAIN = 2, PH_DONE = 3, PH_OVF = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic clear = 1'b0;
    logic done, ovf, err;

    int total = 0;
    int bad = 0;

    instr_enc_loader_if #(.ADDR_W(32)) bus ();

    instr_enc_loader #(
        .ADDR_W     (32),
        .BASE_ADDR  (0),
        .IMEM_WORDS (WORDS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_start    (start),
        .i_clear    (clear),
        .bus_if     (bus),
        .o_done     (done),
        .o_overflow (ovf),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    int m_phase = PH_IDLE;
    int m_issued = 0;
    bit m_ovf = 0;
    bit m_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_enc(input logic [2:0] fmt, input logic [6:0] op,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [31:0] imm);
        logic [31:0] base_r, base_rd;
        base_r  = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        base_rd = (32'(rd) << 7) | 32'(op);
        case (fmt)
            3'd0: return (32'(f7) << 25) | base_r | (32'(rd) << 7);
            3'd1: return ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | base_rd;
            3'd2: return (((imm >> 5) & 32'h7F) << 25) | base_r | ((imm & 32'h1F) << 7);
            3'd3: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | base_r |
                         (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
            3'd4: return (imm & 32'hFFFF_F000) | base_rd;
            3'd5: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                         (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | base_rd;
            3'd6: return 32'h0010_0073;
            default: return 32'h0000_0013;
        endcase
    endfunction

    function automatic bit m_bad(input logic [2:0] fmt, input logic [31:0] imm);
`ifdef ENC_CHECK_EN
        int s;
        s = int'(imm);
        case (fmt)
            3'd1, 3'd2: return (s < -2048) || (s > 2047);
            3'd3: return (s < -4096) || (s > 4095) || (imm[0] == 1'b1);
            3'd5: return (s < -(1 << 20)) || (s > (1 << 20) - 1) || (imm[0] == 1'b1);
            3'd4: return (imm % 4096) != 0;
            default: return 1'b0;
        endcase
`else
        return (fmt == 3'd7) && (imm == 32'h1) && 1'b0;
`endif
    endfunction

    function automatic logic [31:0] lget_data(input int i);
        return (i < log_data.size()) ? log_data[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] lget_addr(input int i);
        return (i < log_addr.size()) ? log_addr[i] : 32'hDEAD_BEEF;
    endfunction

    // Compare process: checks outputs against the model, then advances the model to the next edge.
    always @(negedge clk) begin
        bit accept, empty_now, ready_m;
        if (!rst_n) begin
            chk("rst_wr_en", 32'(bus.imem_wr_en), 0);
            chk("rst_addr", bus.imem_addr, 0);
            chk("rst_wdata", bus.imem_wdata, 0);
            chk("rst_cmd_ready", 32'(bus.cmd_ready), 0);
            chk("rst_flags", {29'd0, done, ovf, err}, 0);
            q_addr.delete();
            q_data.delete();
            m_phase = PH_IDLE;
            m_issued = 0;
            m_ovf = 0;
            m_err = 0;
        end else begin
            empty_now = (q_data.size() == 0);
            ready_m = (m_phase == PH_LOAD) && (q_data.size() < DEPTH);
            chk("cmd_ready", 32'(bus.cmd_ready), 32'(ready_m));
            chk("wr_en", 32'(bus.imem_wr_en), 32'(!empty_now));
            if (!empty_now) begin
                chk("addr", bus.imem_addr, q_addr[0]);
                chk("wdata", bus.imem_wdata, q_data[0]);
            end
            chk("done", 32'(done), 32'(m_phase == PH_DONE));
            chk("overflow", 32'(ovf), 32'(m_ovf));
            chk("err", 32'(err), 32'(m_err));
            if (bus.imem_wr_en && bus.imem_ready) begin
                log_addr.push_back(bus.imem_addr);
                log_data.push_back(bus.imem_wdata);
            end
            if (clear) begin
                q_addr.delete();
                q_data.delete();
                m_phase = PH_IDLE;
                m_issued = 0;
                m_ovf = 0;
                m_err = 0;
            end else begin
                accept = bus.cmd_valid && ready_m;
                if (!empty_now && bus.imem_ready) begin
                    void'(q_addr.pop_front());
                    void'(q_data.pop_front());
                end
                case (m_phase)
                    PH_IDLE: if (start) m_phase = PH_LOAD;
                    PH_LOAD: if (accept) begin
                        if (m_issued == WORDS) begin
                            m_ovf = 1;
                            m_phase = PH_OVF;
                        end else if (m_bad(bus.cmd_fmt, bus.cmd_imm)) begin
                            m_err = 1;
                        end else begin
                            q_addr.push_back(32'(m_issued) * 4);
                            q_data.push_back(m_enc(bus.cmd_fmt, bus.cmd_opcode, bus.cmd_funct3,
                                                   bus.cmd_funct7, bus.cmd_rd, bus.cmd_rs1,
                                                   bus.cmd_rs2, bus.cmd_imm));
                            m_issued++;
                            if (bus.cmd_fmt == 3'd6) m_phase = PH_DRAIN;
                        end
                    end
                    PH_DRAIN: if (empty_now) m_phase = PH_DONE;
                    default: ;
                endcase
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
        bus.cmd_fmt = fmt;
        bus.cmd_opcode = op;
        bus.cmd_funct3 = f3;
        bus.cmd_funct7 = f7;
        bus.cmd_rd = rd;
        bus.cmd_rs1 = rs1;
        bus.cmd_rs2 = rs2;
        bus.cmd_imm = imm;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                @(posedge clk);
                #1;
                bus.cmd_valid = 1'b0;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL send_timeout: cmd_ready stayed 0, expected 1 within 50 cycles");
        bus.cmd_valid = 1'b0;
        tick(1);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("wait_done", 32'(done), 1);
        tick(1);
    endtask

    initial begin
        int n0;
        bus.cmd_valid = 1'b0;
        bus.cmd_fmt = '0;
        bus.cmd_opcode = '0;
        bus.cmd_funct3 = '0;
        bus.cmd_funct7 = '0;
        bus.cmd_rd = '0;
        bus.cmd_rs1 = '0;
        bus.cmd_rs2 = '0;
        bus.cmd_imm = '0;
        bus.imem_ready = 1'b1;
        #22 rst_n = 1'b1;
        tick(1);

        // Session 1: mixed formats, a memory stall, then HALT
        pulse_start();
        send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);        // add x3,x1,x2
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF); // addi x5,x0,-1
        send(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);         // sw x2,8(x1)
        send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8);         // jal x1,8
        tick(3);
        fork
            begin
                bus.imem_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 bus.imem_ready = 1'b1;
            end
            begin
                send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd16);     // beq x1,x2,16
                send(3'd4, 7'h37, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'h1234_5000); // lui x7
                send(3'd7, 7'h00, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);      // reserved
            end
            begin
                repeat (4) @(negedge clk);
                chk("stall_cmd_ready", 32'(bus.cmd_ready), 0);
                chk("stall_wr_en", 32'(bus.imem_wr_en), 1);
                chk("stall_addr", bus.imem_addr, 32'h10);
                chk("stall_wdata", bus.imem_wdata, 32'h0020_8863);
            end
        join
        send(3'd6, 7'h00, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        wait_done();
        chk("done_cmd_ready", 32'(bus.cmd_ready), 0);
        chk("s1_count", 32'(log_data.size()), 8);
        chk("w0_addr", lget_addr(0), 32'h0);
        chk("w0_data", lget_data(0), 32'h0020_81B3);
        chk("w1_addr", lget_addr(1), 32'h4);
        chk("w1_data", lget_data(1), 32'hFFF0_0293);
        chk("w2_addr", lget_addr(2), 32'h8);
        chk("w2_data", lget_data(2), 32'h0020_A423);
        chk("w3_addr", lget_addr(3), 32'hC);
        chk("w3_data", lget_data(3), 32'h0080_00EF);
        chk("w4_data", lget_data(4), 32'h0020_8863);
        chk("w5_data", lget_data(5), 32'h1234_53B7);
        chk("w6_data", lget_data(6), 32'h0000_0013);
        chk("w7_addr", lget_addr(7), 32'h1C);
        chk("w7_data", lget_data(7), 32'h0010_0073);
        pulse_clear();
        chk("clear_done", 32'(done), 0);

        // Session 2: one command more than memory holds
        pulse_start();
        for (int k = 0; k < 9; k++) send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'(k));
        tick(5);
        chk("ovf_flag", 32'(ovf), 1);
        chk("ovf_cmd_ready", 32'(bus.cmd_ready), 0);
        chk("ovf_count", 32'(log_data.size()), 16);
        chk("ovf_first_addr", lget_addr(8), 32'h0);
        chk("ovf_last_addr", lget_addr(15), 32'h1C);
        chk("ovf_last_data", lget_data(15), 32'h0070_0093);
        pulse_clear();
        chk("clear_ovf", 32'(ovf), 0);

        // Session 3: immediate out of range for I-type
        pulse_start();
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096);
        tick(4);
`ifdef ENC_CHECK_EN
        chk("err_flag", 32'(err), 1);
        chk("err_no_write", 32'(log_data.size()), 16);
`else
        chk("err_tied", 32'(err), 0);
        chk("trunc_count", 32'(log_data.size()), 17);
        chk("trunc_data", lget_data(16), 32'h0000_0093);
`endif
        pulse_clear();

        // Session 4: asynchronous reset while a write is pending
        pulse_start();
        bus.imem_ready = 1'b0;
        send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        chk("pre_rst_wr_en", 32'(bus.imem_wr_en), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_wr_en", 32'(bus.imem_wr_en), 0);
        chk("async_addr", bus.imem_addr, 0);
        chk("async_wdata", bus.imem_wdata, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        bus.imem_ready = 1'b1;
        tick(1);
        n0 = log_data.size();
        pulse_start();
        send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        tick(4);
        chk("reload_count", 32'(log_data.size()), 32'(n0 + 1));
        chk("reload_addr", lget_addr(n0), 32'h0);
        chk("reload_data", lget_data(n0), 32'h0020_81B3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1);
    end

endmodule
